sha256_stream_hasher: RTL and testbench

// Multi-block SHA-256 engine on AXI-Stream; parametrised successor to the single-block fixed-IV hasher.
// - Accepts pre-padded 512-bit blocks; rd_tlast marks the final block of a message.
// - Chains the digest across blocks and emits one digest per message with full valid/ready backpressure.
// - Sits between the host read stream and the write stream.

---
 rtl/sha256_pkg.sv | 61 ++++++
 rtl/sha256_stream_hasher_if.sv | 23 ++
 rtl/sha256_round.sv | 17 +
 rtl/sha256_stream_hasher.sv | 116 +++++++++++
 tb/tb_sha256_stream_hasher.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 round constants, IV, round functions and FSM encodings
package sha256_pkg;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // H0 occupies the top word, matching the digest layout on wr_tdata.
    localparam logic [255:0] IV_FLAT = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ROUND = 2'd1;
    localparam state_t ST_FINAL = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sha256_stream_hasher_if.sv
// rtl/sha256_stream_hasher_if.sv - block input stream and digest output stream of the hasher
interface sha256_stream_hasher_if #(
    parameter int OUT_W = 512
);
    logic             rd_tvalid;
    logic             rd_tready;
    logic             rd_tlast;
    logic [511:0]     rd_tdata;
    logic             wr_tvalid;
    logic             wr_tready;
    logic             wr_tlast;
    logic [OUT_W-1:0] wr_tdata;

    modport master (
        output rd_tvalid, rd_tlast, rd_tdata, wr_tready,
        input  rd_tready, wr_tvalid, wr_tlast, wr_tdata
    );

    modport slave (
        input  rd_tvalid, rd_tlast, rd_tdata, wr_tready,
        output rd_tready, wr_tvalid, wr_tlast, wr_tdata
    );
endinterface

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round on packed {a..h}
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] st_out
);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_in;
    assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
    assign t2 = bsig0(a) + maj(a, b, c);
    assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_stream_hasher.sv
// rtl/sha256_stream_hasher.sv - multi-block SHA-256 engine chaining H across blocks, one digest per message
module sha256_stream_hasher
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int OUT_W            = 512,
    parameter bit BYTE_SWAP        = 1'b0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    sha256_stream_hasher_if.slave        strm,
    output logic [31:0]                  msg_count,
    output logic                         busy
);
    localparam int         RPC    = ROUNDS_PER_CYCLE;
    localparam logic [5:0] T_LAST = 6'(64 - RPC);

    state_t       state;
    logic [255:0] h_q;
    logic [255:0] st_q;
    logic [255:0] st_next;
    logic [5:0]   t_q;
    logic         last_q;
    logic [31:0]  w_win  [16];
    logic [31:0]  w_next [16];
    logic [31:0]  w_load [16];

    // Window holds W[t..t+15]; round j of this cycle consumes w_win[j].
    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [255:0] s_in;
        logic [255:0] s_out;
        if (j == 0) begin : g_first
            assign s_in = st_q;
        end else begin : g_chain
            assign s_in = g_rnd[j-1].s_out;
        end
        sha256_round u_round (
            .st_in  (s_in),
            .k      (K[t_q + 6'(j)]),
            .w      (w_win[j]),
            .st_out (s_out)
        );
    end
    assign st_next = g_rnd[RPC-1].s_out;

    // New words W[t+16+j]; for j >= 2 the t-2 term is a word produced this same cycle.
    for (genvar j = 0; j < RPC; j++) begin : g_sch
        logic [31:0] wm2;
        logic [31:0] wn;
        if (j < 2) begin : g_old
            assign wm2 = w_win[14 + j];
        end else begin : g_fresh
            assign wm2 = g_sch[j-2].wn;
        end
        assign wn = ssig1(wm2) + w_win[9 + j] + ssig0(w_win[1 + j]) + w_win[j];
    end

    for (genvar i = 0; i < 16; i++) begin : g_win
        logic [31:0] word;
        assign word      = strm.rd_tdata[511 - 32*i -: 32];
        assign w_load[i] = BYTE_SWAP ? bswap32(word) : word;
        if (i + RPC < 16) begin : g_shift
            assign w_next[i] = w_win[i + RPC];
        end else begin : g_new
            assign w_next[i] = g_sch[i + RPC - 16].wn;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            h_q       <= IV_FLAT;
            st_q      <= '0;
            t_q       <= '0;
            last_q    <= 1'b0;
            msg_count <= '0;
            for (int i = 0; i < 16; i++) w_win[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (strm.rd_tvalid) begin
                        w_win  <= w_load;
                        last_q <= strm.rd_tlast;
                        st_q   <= h_q;
                        t_q    <= '0;
                        state  <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    st_q  <= st_next;
                    w_win <= w_next;
                    t_q   <= t_q + 6'(RPC);
                    if (t_q == T_LAST) state <= ST_FINAL;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) h_q[32*i +: 32] <= h_q[32*i +: 32] + st_q[32*i +: 32];
                    state <= last_q ? ST_OUT : ST_IDLE;
                end
                ST_OUT: begin
                    if (strm.wr_tready) begin
                        h_q       <= IV_FLAT;
                        msg_count <= msg_count + 32'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign strm.rd_tready = aresetn && (state == ST_IDLE);
    assign strm.wr_tvalid = (state == ST_OUT);
    assign strm.wr_tlast  = (state == ST_OUT);
    assign strm.wr_tdata  = (state == ST_OUT) ? OUT_W'(h_q) : '0;
    assign busy           = (state != ST_IDLE);
endmodule

// File: tb/tb_sha256_stream_hasher.sv
// tb/tb_sha256_stream_hasher.sv - directed scoreboard bench over four hasher configurations
module tb_sha256_stream_hasher;
    localparam int NDUT = 4;
    localparam int LAT [NDUT] = '{66, 34, 18, 66};

    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    typedef struct {
        logic [255:0] digest;
        int           lat;
    } exp_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    logic         rd_tvalid [NDUT];
    logic         rd_tlast  [NDUT];
    logic [511:0] rd_tdata  [NDUT];
    logic         wr_tready [NDUT];
    logic         rd_tready [NDUT];
    logic         wr_tvalid [NDUT];
    logic         wr_tlast  [NDUT];
    logic [511:0] wr_tdata  [NDUT];
    logic [31:0]  msg_count [NDUT];
    logic         busy      [NDUT];

    // Configurations: 0 = 1 round/cycle, 1 = 2, 2 = 4, 3 = 1 round/cycle with byte swap.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int RPC = (g == 1) ? 2 : (g == 2) ? 4 : 1;
        localparam bit BS  = (g == 3);
        sha256_stream_hasher_if #(.OUT_W(512)) bus ();
        assign bus.rd_tvalid = rd_tvalid[g];
        assign bus.rd_tlast  = rd_tlast[g];
        assign bus.rd_tdata  = rd_tdata[g];
        assign bus.wr_tready = wr_tready[g];
        assign rd_tready[g]  = bus.rd_tready;
        assign wr_tvalid[g]  = bus.wr_tvalid;
        assign wr_tlast[g]   = bus.wr_tlast;
        assign wr_tdata[g]   = bus.wr_tdata;
        sha256_stream_hasher #(
            .ROUNDS_PER_CYCLE (RPC),
            .OUT_W            (512),
            .BYTE_SWAP        (BS)
        ) dut (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .strm      (bus),
            .msg_count (msg_count[g]),
            .busy      (busy[g])
        );
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   hs_cyc  [NDUT];
    int   exp_cnt [NDUT];
    exp_t sb [$];

    task automatic chk(input int idx, input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL dut%0d %s observed=%0h expected=%0h", idx, tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] swap_words(input logic [511:0] b);
        logic [511:0] r;
        for (int i = 0; i < 16; i++)
            r[32*i +: 32] = {b[32*i +: 8], b[32*i+8 +: 8], b[32*i+16 +: 8], b[32*i+24 +: 8]};
        return r;
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input int idx, input logic [511:0] blk, input logic last);
        int n = 0;
        rd_tdata[idx]  = (idx == 3) ? swap_words(blk) : blk;
        rd_tlast[idx]  = last;
        rd_tvalid[idx] = 1'b1;
        while (rd_tready[idx] !== 1'b1 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        chk(idx, "rd_accept", 512'(rd_tready[idx]), 512'(1'b1));
        @(negedge aclk);
        rd_tvalid[idx] = 1'b0;
        hs_cyc[idx]    = cyc;
    endtask

    task automatic expect_msg(input logic [255:0] digest, input int lat);
        exp_t e;
        e.digest = digest;
        e.lat    = lat;
        sb.push_back(e);
    endtask

    task automatic collect(input int idx, input int hold, input string tag);
        exp_t         e;
        logic [511:0] exp_data;
        int           n = 0;
        while (wr_tvalid[idx] !== 1'b1 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        e        = sb.pop_front();
        exp_data = {256'h0, e.digest};
        chk(idx, {tag, "_valid"}, 512'(wr_tvalid[idx]), 512'(1'b1));
        chk(idx, {tag, "_latency"}, 512'(cyc + 1 - hs_cyc[idx]), 512'(e.lat));
        if (hold > 0) begin
            wr_tready[idx] = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge aclk);
                chk(idx, {tag, "_hold_rd_tready"}, 512'(rd_tready[idx]), 512'(1'b0));
                chk(idx, {tag, "_hold_valid"}, 512'(wr_tvalid[idx]), 512'(1'b1));
                chk(idx, {tag, "_hold_data"}, wr_tdata[idx], exp_data);
            end
            wr_tready[idx] = 1'b1;
        end
        chk(idx, {tag, "_digest"}, wr_tdata[idx], exp_data);
        chk(idx, {tag, "_tlast"}, 512'(wr_tlast[idx]), 512'(1'b1));
        @(negedge aclk);
        exp_cnt[idx]++;
        chk(idx, {tag, "_single_beat"}, 512'(wr_tvalid[idx]), 512'(1'b0));
        chk(idx, {tag, "_msg_count"}, 512'(msg_count[idx]), 512'(exp_cnt[idx]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rd_tvalid[i] = 1'b0;
            rd_tlast[i]  = 1'b0;
            rd_tdata[i]  = '0;
            wr_tready[i] = 1'b1;
            hs_cyc[i]    = 0;
            exp_cnt[i]   = 0;
        end
        repeat (3) @(negedge aclk);
        chk(0, "rst_rd_tready", 512'(rd_tready[0]), 512'(1'b0));
        chk(0, "rst_wr_tvalid", 512'(wr_tvalid[0]), 512'(1'b0));
        chk(0, "rst_wr_tlast", 512'(wr_tlast[0]), 512'(1'b0));
        chk(0, "rst_wr_tdata", wr_tdata[0], 512'h0);
        chk(0, "rst_msg_count", 512'(msg_count[0]), 512'h0);
        chk(0, "rst_busy", 512'(busy[0]), 512'(1'b0));
        aresetn = 1'b1;
        @(negedge aclk);
        for (int i = 0; i < NDUT; i++) chk(i, "idle_rd_tready", 512'(rd_tready[i]), 512'(1'b1));

        for (int i = 0; i < NDUT; i++) begin
            send(i, B_ABC, 1'b1);
            expect_msg(D_ABC, LAT[i]);
            collect(i, 0, "abc");
            send(i, B_EMPTY, 1'b1);
            expect_msg(D_EMPTY, LAT[i]);
            collect(i, 0, "empty");
            send(i, B_TWO1, 1'b0);
            send(i, B_TWO2, 1'b1);
            expect_msg(D_TWO, LAT[i]);
            collect(i, 0, "two_block");
        end

        // Back-to-back with the second block waiting upstream while the first digest is held.
        send(0, B_ABC, 1'b1);
        expect_msg(D_ABC, LAT[0]);
        rd_tdata[0]  = B_EMPTY;
        rd_tlast[0]  = 1'b1;
        rd_tvalid[0] = 1'b1;
        collect(0, 20, "bp_abc");
        chk(0, "bp_rd_tready_after", 512'(rd_tready[0]), 512'(1'b1));
        @(negedge aclk);
        rd_tvalid[0] = 1'b0;
        hs_cyc[0]    = cyc;
        expect_msg(D_EMPTY, LAT[0]);
        collect(0, 0, "bp_empty");

        // Abort a two-block message mid-round.
        send(0, B_TWO1, 1'b0);
        repeat (10) @(negedge aclk);
        chk(0, "abort_busy", 512'(busy[0]), 512'(1'b1));
        aresetn = 1'b0;
        @(negedge aclk);
        chk(0, "abort_busy_rst", 512'(busy[0]), 512'(1'b0));
        chk(0, "abort_wr_tvalid", 512'(wr_tvalid[0]), 512'(1'b0));
        chk(0, "abort_msg_count", 512'(msg_count[0]), 512'h0);
        chk(0, "abort_rd_tready", 512'(rd_tready[0]), 512'(1'b0));
        aresetn = 1'b1;
        for (int i = 0; i < NDUT; i++) exp_cnt[i] = 0;
        @(negedge aclk);
        send(0, B_ABC, 1'b1);
        expect_msg(D_ABC, LAT[0]);
        collect(0, 0, "post_abort_abc");
        repeat (5) @(negedge aclk);
        chk(0, "final_wr_tvalid", 512'(wr_tvalid[0]), 512'(1'b0));
        chk(0, "final_busy", 512'(busy[0]), 512'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
